pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic parametrised pipeline stage register that replaces the fixed per-stage
//  registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB) of the 5-stage MIPS core.
//  - Carries a control bundle and a data bundle between stages.
//  - Uses a valid/ready handshake, so hazard logic can stall, flush or insert bubbles.
//  - Control bits (wreg, m2reg, wmem, ...) are forced to zero on bubbles, so a
//    killed instruction never writes architectural state.
// PARAMETERS
//  DATA_W  128  width of data bundle (e.g. a, b, imm, pc4)
//  CTRL_W  16   width of control bundle (e.g. rn, aluc, wreg, m2reg, wmem, ...)
//  CNT_W   16   width of saturating stall-cycle counter
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  flush      in   1       synchronous kill of all held entries (branch/jump redirect)
//  in_valid   in   1       upstream stage presents a valid instruction
//  in_ready   out  1       this stage can accept this cycle
//  in_ctrl    in   CTRL_W  upstream control bundle
//  in_data    in   DATA_W  upstream data bundle
//  out_valid  out  1       held instruction is valid
//  out_ready  in   1       downstream stage accepts this cycle
//  out_ctrl   out  CTRL_W  registered control; 0 whenever out_valid=0
//  out_data   out  DATA_W  registered data; holds last loaded value on bubble
//  stall_cnt  out  CNT_W   cycles with out_valid=1 and out_ready=0, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, skid entry empty.
//   - Outputs take these values immediately, not on the next clock edge.
//  Handshake:
//   - Accept = in_valid & in_ready. Emit = out_valid & out_ready.
//   - in_valid must not depend combinationally on in_ready.
//   - Latency: an accepted beat appears on out_* on the next rising edge.
//   - Sustained throughput: 1 beat/cycle.
//  Main register:
//   - Loads in_ctrl/in_data and sets out_valid=1 when it is empty or emitting.
//   - Emit without accept (and no skid entry to refill from) leaves a bubble:
//     out_valid=0, out_ctrl=0, out_data unchanged.
//  Stall:
//   - out_valid=1 & out_ready=0: all of out_* hold exactly.
//  Flush (priority over everything except reset):
//   - At the edge: out_valid=0, out_ctrl=0, skid emptied.
//   - A beat accepted in the flush cycle is discarded.
//   - out_data holds. in_ready is not gated by flush.
//  stall_cnt:
//   - +1 per cycle with out_valid & ~out_ready.
//   - Saturates at 2^CNT_W-1.
//   - Cleared only by reset; unaffected by flush.
//  Simultaneous accept + emit, non-skid build: main register reloads the same edge;
//   out_valid stays 1.
//  Reset mid-transfer: all in-flight beats are lost; no partial state survives.
// CONFIGURATION
//  PIPE_STAGE_SKID_EN defined:
//   - Adds a one-entry skid register (ctrl+data+valid).
//   - in_ready = ~skid_valid, driven straight from a flop; no combinational
//     out_ready->in_ready path.
//   - Accept while main is full and not emitting: the beat goes to skid.
//   - Emit while skid is full: main loads from skid; skid then takes a
//     same-cycle accept, or empties.
//   - Order is preserved; capacity is 2.
//  PIPE_STAGE_SKID_EN undefined:
//   - No skid register; capacity is 1.
//   - in_ready = ~out_valid | out_ready, a combinational path from out_ready.
// TESTING
//  1 Reset: hold rst_n=0 with in_valid=1, in_ctrl=16'hFFFF
//    -> out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0.
//  2 Streaming: out_ready=1, send 8 beats data=1..8 back-to-back
//    -> out_data=1..8 on consecutive cycles, each 1 cycle after accept, no gaps.
//  3 Stall: beat A held, out_ready=0 for 5 cycles
//    -> out_* constant, stall_cnt=5. With SKID_EN: one extra beat B accepted,
//       then in_ready=0, and out_ready=1 gives A then B.
//  4 Flush: flush=1 while holding A and accepting B
//    -> next cycle out_valid=0, out_ctrl=0, neither A nor B ever emitted.
//  5 Bubble: in_valid=0, out_ready=1 after beat C
//    -> out_valid=0, out_ctrl=0, out_data=C.
//  6 Saturation: CNT_W=4, stall 20 cycles -> stall_cnt=15.
//    Then a mid-stall reset -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Generic pipeline stage register for the 5-stage MIPS core. It replaces the
//   fixed IF/ID, ID/EXE, EXE/MEM and MEM/WB registers. It moves a control bundle
//   and a data bundle from one stage to the next with a valid/ready handshake.
//   Control bits are zero whenever the stage holds a bubble, so a killed
//   instruction can never write architectural state.
//
//   Optional feature (compile-time macro PIPE_STAGE_SKID_EN):
//     defined   - a one-entry skid register is added (capacity 2). in_ready
//                 comes straight from a flop, so there is no combinational path
//                 from out_ready to in_ready.
//     undefined - there is no skid register (capacity 1). in_ready is
//                 ~out_valid | out_ready, which is combinational.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   flush      in   1       synchronous kill of all held entries
//   in_valid   in   1       upstream presents a beat
//   in_ready   out  1       this stage can accept this cycle
//   in_ctrl    in   CTRL_W  upstream control bundle
//   in_data    in   DATA_W  upstream data bundle
//   out_valid  out  1       held beat is valid
//   out_ready  in   1       downstream accepts this cycle
//   out_ctrl   out  CTRL_W  registered control, zero while out_valid=0
//   out_data   out  DATA_W  registered data, holds last loaded value on bubble
//   stall_cnt  out  CNT_W   saturating count of out_valid & ~out_ready cycles
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic accept_s;
    logic emit_s;

    assign accept_s  = in_valid & in_ready;
    assign emit_s    = valid_q & out_ready;

    assign out_valid = valid_q;
    assign out_ctrl  = ctrl_q;
    assign out_data  = data_q;
    assign stall_cnt = cnt_q;

    // Stall counter: counts held-but-not-taken cycles and sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (valid_q && !out_ready && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;

    // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
    assign in_ready = ~skid_valid_q;

    // Next-state for main and skid entries. Skid is only ever full while main is full.
    always_comb begin
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        data_d       = data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            // Drop everything held, including a beat accepted this cycle; data holds.
            valid_d      = 1'b0;
            ctrl_d       = {CTRL_W{1'b0}};
            skid_valid_d = 1'b0;
        end else if (!valid_q) begin
            if (accept_s) begin
                valid_d = 1'b1;
                ctrl_d  = in_ctrl;
                data_d  = in_data;
            end else begin
                valid_d = 1'b0;
            end
        end else if (emit_s) begin
            if (skid_valid_q) begin
                // Refill from skid first so that order is preserved.
                valid_d      = 1'b1;
                ctrl_d       = skid_ctrl_q;
                data_d       = skid_data_q;
                skid_valid_d = accept_s;
                skid_ctrl_d  = in_ctrl;
                skid_data_d  = in_data;
            end else if (accept_s) begin
                valid_d = 1'b1;
                ctrl_d  = in_ctrl;
                data_d  = in_data;
            end else begin
                // Bubble: control cleared, data left as last loaded.
                valid_d = 1'b0;
                ctrl_d  = {CTRL_W{1'b0}};
            end
        end else begin
            if (accept_s) begin
                // Main is stalled; park the new beat in the skid entry.
                skid_valid_d = 1'b1;
                skid_ctrl_d  = in_ctrl;
                skid_data_d  = in_data;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
    end

    // Skid entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= {CTRL_W{1'b0}};
            skid_data_q  <= {DATA_W{1'b0}};
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    // Without a skid entry the stage can take a beat only if it is empty or draining.
    assign in_ready = ~valid_q | out_ready;

    // Next-state for the single main entry.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush) begin
            // Drop the held beat and any beat accepted this cycle; data holds.
            valid_d = 1'b0;
            ctrl_d  = {CTRL_W{1'b0}};
        end else if (accept_s) begin
            valid_d = 1'b1;
            ctrl_d  = in_ctrl;
            data_d  = in_data;
        end else if (emit_s) begin
            // Bubble: control cleared, data left as last loaded.
            valid_d = 1'b0;
            ctrl_d  = {CTRL_W{1'b0}};
        end else begin
            valid_d = valid_q;
        end
    end
`endif

    // Main output registers and stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= {CTRL_W{1'b0}};
            data_q  <= {DATA_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Self-checking bench for pipe_stage_reg. A reference model treats the stage
//   as an ordered queue with a capacity of 1 (or 2 when PIPE_STAGE_SKID_EN is
//   defined). The head of the queue is what appears on out_*. Directed scenarios
//   run first, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DATA_W  = 32;
    localparam int CTRL_W  = 16;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [CTRL_W-1:0] mq_c[$];
    logic [DATA_W-1:0] mq_d[$];
    logic [DATA_W-1:0] m_last;
    int                m_cnt;

`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_ready(input logic ordy);
        if (CAP == 2) return (mq_c.size() < 2);
        else          return (mq_c.size() == 0) || ordy;
    endfunction

    task automatic check_outputs(input string tag);
        logic              e_valid;
        logic [CTRL_W-1:0] e_ctrl;
        e_valid = (mq_c.size() > 0);
        e_ctrl  = e_valid ? mq_c[0] : 16'h0000;
        check_eq({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, e_valid});
        check_eq({tag, ".out_ctrl"},  {48'd0, out_ctrl},  {48'd0, e_ctrl});
        check_eq({tag, ".out_data"},  {32'd0, out_data},  {32'd0, m_last});
        check_eq({tag, ".stall_cnt"}, {60'd0, stall_cnt}, 64'(m_cnt));
    endtask

    // One clock cycle: drive, check in_ready, advance the model, check outputs.
    task automatic cycle(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                         input logic ordy, input logic fl);
        logic m_rdy, acc, emi;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        m_rdy = model_ready(ordy);
        check_eq("in_ready", {63'd0, in_ready}, {63'd0, m_rdy});
        acc = v & m_rdy;
        emi = (mq_c.size() > 0) & ordy;
        if ((mq_c.size() > 0) && !ordy && (m_cnt < CNT_MAX)) m_cnt++;
        if (fl) begin
            mq_c.delete();
            mq_d.delete();
        end else begin
            if (emi) begin
                void'(mq_c.pop_front());
                void'(mq_d.pop_front());
            end
            if (acc) begin
                mq_c.push_back(c);
                mq_d.push_back(d);
            end
        end
        if (mq_c.size() > 0) m_last = mq_d[0];
        @(posedge clk);
        #1;
        check_outputs("cyc");
    endtask

    // Asynchronous reset with junk on the inputs; outputs checked before any edge.
    task automatic do_reset();
        in_valid  = 1'b1;
        in_ctrl   = 16'hFFFF;
        in_data   = 32'hFFFF_FFFF;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst_n     = 1'b0;
        mq_c.delete();
        mq_d.delete();
        m_last = '0;
        m_cnt  = 0;
        #2;
        check_outputs("rst_async");
        check_eq("rst_async.in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        m_last    = '0;
        m_cnt     = 0;
        #1;

        // 1: reset
        do_reset();

        // 2: streaming 8 beats back-to-back
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 16'(16'h0100 + i), 32'(i), 1'b1, 1'b0);
            check_eq("stream.data", {32'd0, out_data}, 64'(i));
            check_eq("stream.valid", {63'd0, out_valid}, 64'd1);
        end
        cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);

        // 3: stall with A held, B offered
        do_reset();
        cycle(1'b1, 16'h00AA, 32'hAAAA_0001, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 16'h00BB, 32'hBBBB_0002, 1'b0, 1'b0);
            check_eq("stall.data_hold", {32'd0, out_data}, 64'h0000_0000_AAAA_0001);
        end
        check_eq("stall.cnt5", {60'd0, stall_cnt}, 64'd5);
        cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
        check_eq("stall.skid_b", {32'd0, out_data}, 64'h0000_0000_BBBB_0002);
`else
        check_eq("stall.bubble", {63'd0, out_valid}, 64'd0);
`endif
        cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);

        // 4: flush while holding A and offering B
        do_reset();
        cycle(1'b1, 16'h00A1, 32'hA1A1_A1A1, 1'b1, 1'b0);
        cycle(1'b1, 16'h00B1, 32'hB1B1_B1B1, 1'b0, 1'b1);
        check_eq("flush.valid", {63'd0, out_valid}, 64'd0);
        check_eq("flush.ctrl",  {48'd0, out_ctrl},  64'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
            check_eq("flush.never", {63'd0, out_valid}, 64'd0);
        end

        // 5: bubble after beat C
        cycle(1'b1, 16'h00CC, 32'hCCCC_CCCC, 1'b1, 1'b0);
        cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
        check_eq("bubble.valid", {63'd0, out_valid}, 64'd0);
        check_eq("bubble.ctrl",  {48'd0, out_ctrl},  64'd0);
        check_eq("bubble.data",  {32'd0, out_data},  64'h0000_0000_CCCC_CCCC);

        // 6: saturation, then mid-stall asynchronous reset
        do_reset();
        cycle(1'b1, 16'h00DD, 32'hDDDD_DDDD, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
        check_eq("sat.cnt15", {60'd0, stall_cnt}, 64'd15);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ((i % 150) == 149) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 1)), 16'($urandom), 32'($urandom),
                      1'($urandom_range(0, 3) != 0 ? 1 : 0),
                      1'($urandom_range(0, 19) == 0 ? 1 : 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
